// File: rtl/fdce_pkg.sv
// fdce_pkg: CPU-wide datapath constants shared by storage elements.
//   DATA_WIDTH - width of a datapath register (register file, PC bytes)
//   FLAG_WIDTH - width of a single status flag
package fdce_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int FLAG_WIDTH = 1;
endpackage

// File: rtl/fdce.sv
// fdce: D register with clock enable and asynchronous active-high clear.
// Basic state element of the CPU datapath (flags at WIDTH=1, registers at
// WIDTH=DATA_WIDTH).
// Ports:
//   d            - data captured on a rising clock edge when enabled
//   clock        - rising-edge clock
//   clock_enable - active-high load enable
//   clear        - active-high asynchronous clear, forces q to zero
//   q            - registered state
module fdce
   import fdce_pkg::*;
#(
   parameter int               WIDTH = FLAG_WIDTH,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic [WIDTH-1:0] d,
   input  logic             clock,
   input  logic             clock_enable,
   input  logic             clear,
   output logic [WIDTH-1:0] q
);

   // Declaration initializer gives the power-up value (FPGA bitstream init).
   logic [WIDTH-1:0] q_r = INIT;

   // Clear is in the sensitivity list, so it takes effect mid-cycle and
   // overrides a coincident clock edge.
   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         q_r <= '0;
      else if (clock_enable)
         q_r <= d;
   end

   assign q = q_r;

endmodule

// File: tb/tb_fdce.sv
// tb_fdce: directed-vector bench for fdce (1-bit, 8-bit, and nonzero INIT).
module tb_fdce;
   import fdce_pkg::*;

   logic clock = 1'b0;
   always #25 clock = ~clock;   // rising edges at 25, 75, 125, ...

   // 1-bit flag instance
   logic d1, ce1, clr1, q1;
   // 8-bit register instance
   logic [7:0] d8, q8;
   logic ce8, clr8;
   // 8-bit instance with nonzero power-up value
   logic [7:0] di, qi;
   logic cei, clri;

   fdce u_flag (.d(d1), .clock(clock), .clock_enable(ce1), .clear(clr1), .q(q1));

   fdce #(.WIDTH(DATA_WIDTH)) u_reg
      (.d(d8), .clock(clock), .clock_enable(ce8), .clear(clr8), .q(q8));

   fdce #(.WIDTH(DATA_WIDTH), .INIT(8'h3C)) u_init
      (.d(di), .clock(clock), .clock_enable(cei), .clear(clri), .q(qi));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
   endtask

   task automatic at(input int t);
      if (longint'($time) < t) #(longint'(t) - longint'($time));
   endtask

   initial begin
      d1 = 1'b1; ce1 = 1'b1; clr1 = 1'b0;
      d8 = 8'h00; ce8 = 1'b0; clr8 = 1'b0;
      di = 8'hFF; cei = 1'b0; clri = 1'b0;

      // Power-up values before any edge
      at(1);
      chk("init_flag", {7'b0, q1}, 8'h00);
      chk("init_reg",  q8, 8'h00);
      chk("init_3c",   qi, 8'h3C);

      // Load 1, hold through t=100
      at(30);  chk("load1",      {7'b0, q1}, 8'h01);
      at(90);  chk("load1_hold", {7'b0, q1}, 8'h01);

      // Load 0
      at(100); d1 = 1'b0;
      at(130); chk("load0", {7'b0, q1}, 8'h00);

      // Clear held high; d=1 and ce=1 must not load
      at(200); d1 = 1'b0; ce1 = 1'b1; clr1 = 1'b1;
      at(201); chk("clr_on",   {7'b0, q1}, 8'h00);
      at(300); d1 = 1'b1;
      at(330); chk("clr_d1_a", {7'b0, q1}, 8'h00);
      at(390); chk("clr_d1_b", {7'b0, q1}, 8'h00);

      // Enable low: hold 0 despite d=1
      at(400); d1 = 1'b1; ce1 = 1'b0; clr1 = 1'b0;
      at(430); chk("ce0_hold_a", {7'b0, q1}, 8'h00);
      at(490); chk("ce0_hold_b", {7'b0, q1}, 8'h00);

      // Load 1, then disable
      at(500); d1 = 1'b1; ce1 = 1'b1;
      at(530); chk("reload1", {7'b0, q1}, 8'h01);
      at(600); d1 = 1'b0; ce1 = 1'b0;
      at(605); chk("ce0_hold1", {7'b0, q1}, 8'h01);

      // Mid-cycle clear pulse, no clock edge involved
      at(610); clr1 = 1'b1;
      at(611); chk("midclr", {7'b0, q1}, 8'h00);
      at(615); clr1 = 1'b0;
      at(630); chk("midclr_after_a", {7'b0, q1}, 8'h00);
      at(680); chk("midclr_after_b", {7'b0, q1}, 8'h00);

      // 8-bit: load A5, no change before the edge
      at(700); d8 = 8'hA5; ce8 = 1'b1;
      at(710); chk("reg_no_comb", q8, 8'h00);
      at(730); chk("reg_a5", q8, 8'hA5);
      at(740); d8 = 8'h5A; ce8 = 1'b0;
      at(760); chk("reg_hold", q8, 8'hA5);
      // Clear mid-cycle, held across the edge at 775 with ce=1
      clr8 = 1'b1; ce8 = 1'b1;
      at(761); chk("reg_clr", q8, 8'h00);
      at(780); chk("reg_clr_edge", q8, 8'h00);
      at(790); clr8 = 1'b0; d8 = 8'hFF;
      at(830); chk("reg_ff", q8, 8'hFF);
      // d toggles between edges with ce=1 only matter at the edge
      at(840); d8 = 8'h12;
      at(845); d8 = 8'h34;
      at(850); chk("reg_between", q8, 8'hFF);
      at(880); chk("reg_34", q8, 8'h34);

      // Nonzero-INIT instance: clear, then load
      at(890); clri = 1'b1;
      at(891); chk("init_clr", qi, 8'h00);
      at(900); clri = 1'b0; cei = 1'b1; di = 8'hC3;
      at(930); chk("init_load", qi, 8'hC3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
